// File: rtl/calc_exec_unit.sv
// calc_exec_unit: arithmetic responder for the calculator control unit.
// Accepts a one-cycle operation strobe with operands num1/num2, runs the
// operation in one or several cycles, then returns a one-cycle done pulse
// together with result, remainder and status flags.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   add/sub/mult/div  start strobes for the arithmetic operations
//   gcd/isprime/sqrt  start strobes for the iterative operations
//   num1, num2        operands, sampled when a strobe is accepted in IDLE
//   busy              high while a multi-cycle operation is running
//   done              one-cycle completion pulse (while in FIN)
//   result            primary result (2*WIDTH), held until the next accept
//   remainder         div/sqrt remainder, held
//   prime             isprime verdict, held
//   err               divide-by-zero or illegal strobe combination, held
module calc_exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 add,
  input  logic                 sub,
  input  logic                 mult,
  input  logic                 div,
  input  logic                 gcd,
  input  logic                 isprime,
  input  logic                 sqrt,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     remainder,
  output logic                 prime,
  output logic                 err
);

  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, DIV, GCD, PRIME, SQRT, FIN} state_t;

  state_t state, state_next;

  // a_reg/b_reg: operands (gcd works on both; isprime keeps n in a_reg and
  // the trial divisor in b_reg). q_reg is the dividend/quotient shifter, or
  // the radicand shifter for sqrt. r_reg is the partial remainder.
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [WIDTH-1:0]   q_reg, q_next;
  logic [WIDTH-1:0]   r_reg, r_next;
  logic [HW-1:0]      root_reg, root_next;
  logic [CW-1:0]      cnt, cnt_next;
  logic [2*WIDTH-1:0] result_next;
  logic [WIDTH-1:0]   remainder_next;
  logic               prime_next, err_next;

  logic [6:0]         strobes;
  logic               one_hot, multi;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem, div_quo;
  logic [WIDTH-1:0]   sq_val, sq_trial, sq_rem;
  logic               sq_ge;
  logic [HW-1:0]      sq_root;
  logic [2*WIDTH-1:0] d_sq;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath and output registers; reset clears everything so an aborted
  // operation leaves no trace on the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      root_reg  <= '0;
      cnt       <= '0;
      result    <= '0;
      remainder <= '0;
      prime     <= 1'b0;
      err       <= 1'b0;
    end else begin
      a_reg     <= a_next;
      b_reg     <= b_next;
      q_reg     <= q_next;
      r_reg     <= r_next;
      root_reg  <= root_next;
      cnt       <= cnt_next;
      result    <= result_next;
      remainder <= remainder_next;
      prime     <= prime_next;
      err       <= err_next;
    end
  end

  // Next-state, datapath step and output logic.
  always_comb begin
    state_next     = state;
    a_next         = a_reg;
    b_next         = b_reg;
    q_next         = q_reg;
    r_next         = r_reg;
    root_next      = root_reg;
    cnt_next       = cnt;
    result_next    = result;
    remainder_next = remainder;
    prime_next     = prime;
    err_next       = err;

    strobes = {add, sub, mult, div, gcd, isprime, sqrt};
    // x & (x-1) clears the lowest set bit, so it is nonzero iff 2+ bits set.
    multi   = (strobes & (strobes - 7'd1)) != 7'd0;
    one_hot = (strobes != 7'd0) && !multi;

    // Restoring divider step: shift in the next dividend bit, subtract the
    // divisor if it fits. When it does not fit the shifted value is below
    // the divisor, so its top bit is zero and WIDTH bits suffice.
    div_shift = {r_reg, q_reg[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_reg};
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - b_reg) : div_shift[WIDTH-1:0];
    div_quo   = {q_reg[WIDTH-2:0], div_ge};

    // Digit-by-digit square root step: bring down two radicand bits and try
    // subtracting 4*root+1. The partial remainder never exceeds 2*root, so
    // dropping its top two bits before the shift loses nothing.
    sq_val   = {r_reg[WIDTH-3:0], q_reg[WIDTH-1:WIDTH-2]};
    sq_trial = {{(WIDTH-HW-2){1'b0}}, root_reg, 2'b01};
    sq_ge    = sq_val >= sq_trial;
    sq_rem   = sq_ge ? (sq_val - sq_trial) : sq_val;
    sq_root  = {root_reg[HW-2:0], sq_ge};

    d_sq = {{WIDTH{1'b0}}, b_reg} * {{WIDTH{1'b0}}, b_reg};

    busy = (state == DIV) || (state == GCD) || (state == PRIME) || (state == SQRT);
    done = (state == FIN);

    case (state)
      IDLE: begin
        if (multi) begin
          state_next     = FIN;
          err_next       = 1'b1;
          prime_next     = 1'b0;
          result_next    = '0;
          remainder_next = '0;
        end else if (one_hot) begin
          a_next     = num1;
          b_next     = num2;
          q_next     = num1;
          r_next     = '0;
          root_next  = '0;
          cnt_next   = '0;
          err_next   = 1'b0;
          prime_next = 1'b0;
          if (add) begin
            state_next     = FIN;
            result_next    = {{(WIDTH-1){1'b0}}, {1'b0, num1} + {1'b0, num2}};
            remainder_next = '0;
          end else if (sub) begin
            state_next     = FIN;
            result_next    = {{WIDTH{1'b0}}, num1} - {{WIDTH{1'b0}}, num2};
            remainder_next = '0;
          end else if (mult) begin
            state_next     = FIN;
            result_next    = {{WIDTH{1'b0}}, num1} * {{WIDTH{1'b0}}, num2};
            remainder_next = '0;
          end else if (div) begin
            if (num2 == '0) begin
              state_next     = FIN;
              err_next       = 1'b1;
              result_next    = '1;
              remainder_next = num1;
            end else begin
              state_next = DIV;
            end
          end else if (gcd) begin
            state_next = GCD;
          end else if (isprime) begin
            if (num1 < WIDTH'(2)) begin
              state_next     = FIN;
              result_next    = '0;
              remainder_next = '0;
            end else begin
              b_next     = WIDTH'(2);
              state_next = PRIME;
            end
          end else begin
            state_next = SQRT;
          end
        end
      end

      DIV: begin
        q_next   = div_quo;
        r_next   = div_rem;
        cnt_next = cnt + CW'(1);
        if (cnt == CW'(WIDTH-1)) begin
          state_next     = FIN;
          result_next    = {{WIDTH{1'b0}}, div_quo};
          remainder_next = div_rem;
        end
      end

      GCD: begin
        if (a_reg == '0 || b_reg == '0 || a_reg == b_reg) begin
          state_next     = FIN;
          result_next    = {{WIDTH{1'b0}}, (a_reg == '0) ? b_reg : a_reg};
          remainder_next = '0;
        end else if (a_reg > b_reg) begin
          a_next = a_reg - b_reg;
        end else begin
          b_next = b_reg - a_reg;
        end
      end

      // One trial division of n (a_reg) by d (b_reg) per WIDTH cycles; the
      // verdict is taken on the last step using the final remainder.
      PRIME: begin
        q_next   = div_quo;
        r_next   = div_rem;
        cnt_next = cnt + CW'(1);
        if (cnt == CW'(WIDTH-1)) begin
          if (div_rem == '0 && b_reg < a_reg) begin
            state_next     = FIN;
            prime_next     = 1'b0;
            result_next    = {{WIDTH{1'b0}}, b_reg};
            remainder_next = '0;
          end else if (d_sq > {{WIDTH{1'b0}}, a_reg} || b_reg == a_reg) begin
            state_next     = FIN;
            prime_next     = 1'b1;
            result_next    = {{WIDTH{1'b0}}, a_reg};
            remainder_next = '0;
          end else begin
            b_next   = b_reg + WIDTH'(1);
            q_next   = a_reg;
            r_next   = '0;
            cnt_next = '0;
          end
        end
      end

      SQRT: begin
        q_next    = {q_reg[WIDTH-3:0], 2'b00};
        r_next    = sq_rem;
        root_next = sq_root;
        cnt_next  = cnt + CW'(1);
        if (cnt == CW'(HW-1)) begin
          state_next     = FIN;
          result_next    = {{(2*WIDTH-HW){1'b0}}, sq_root};
          remainder_next = sq_rem;
        end
      end

      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_calc_exec_unit.sv
// tb_calc_exec_unit: directed-vector bench for calc_exec_unit. Each vector
// pulses one strobe set, waits (bounded) for done and compares the held
// outputs against hand-computed values.
module tb_calc_exec_unit;

  localparam logic [6:0] OP_ADD   = 7'b1000000;
  localparam logic [6:0] OP_SUB   = 7'b0100000;
  localparam logic [6:0] OP_MULT  = 7'b0010000;
  localparam logic [6:0] OP_DIV   = 7'b0001000;
  localparam logic [6:0] OP_GCD   = 7'b0000100;
  localparam logic [6:0] OP_PRIME = 7'b0000010;
  localparam logic [6:0] OP_SQRT  = 7'b0000001;
  localparam int         LIMIT    = 500;

  logic        clk;
  logic        reset;
  logic        add, sub, mult, div, gcd, isprime, sqrt;
  logic [7:0]  num1, num2;
  logic        busy, done;
  logic [15:0] result;
  logic [7:0]  remainder;
  logic        prime, err;

  int vec_count;
  int miss_count;
  int latency;
  int done_count;
  bit busy_first;

  calc_exec_unit #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .add(add),
    .sub(sub),
    .mult(mult),
    .div(div),
    .gcd(gcd),
    .isprime(isprime),
    .sqrt(sqrt),
    .num1(num1),
    .num2(num2),
    .busy(busy),
    .done(done),
    .result(result),
    .remainder(remainder),
    .prime(prime),
    .err(err)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every vector and reports miscompares.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Pulses the given strobes for one cycle, then waits at most LIMIT cycles
  // for done. lat is the number of rising edges from accept to the edge that
  // samples done. The pulse is also checked to last exactly one cycle.
  task automatic applyStimulus(input logic [6:0] ops, input logic [7:0] a,
                               input logic [7:0] b, output int lat,
                               output bit busy1);
    bit got;
    got   = 1'b0;
    lat   = 0;
    busy1 = 1'b0;
    @(negedge clk);
    {add, sub, mult, div, gcd, isprime, sqrt} = ops;
    num1 = a;
    num2 = b;
    for (int i = 1; i <= LIMIT; i++) begin
      @(negedge clk);
      if (i == 1) begin
        {add, sub, mult, div, gcd, isprime, sqrt} = 7'b0;
        busy1 = busy;
      end
      if (done) begin
        lat = i;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checkOutput("timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      checkOutput("done_width", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    reset      = 1'b1;
    {add, sub, mult, div, gcd, isprime, sqrt} = 7'b0;
    num1 = 8'd0;
    num2 = 8'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_result", {16'd0, result}, 32'd0);
    checkOutput("rst_rem", {24'd0, remainder}, 32'd0);
    checkOutput("rst_prime", {31'd0, prime}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;

    // Single-cycle operations.
    applyStimulus(OP_ADD, 8'd200, 8'd100, latency, busy_first);
    checkOutput("add_lat", latency, 32'd1);
    checkOutput("add_busy", {31'd0, busy_first}, 32'd0);
    checkOutput("add_result", {16'd0, result}, 32'h012C);
    checkOutput("add_err", {31'd0, err}, 32'd0);
    applyStimulus(OP_ADD, 8'd255, 8'd255, latency, busy_first);
    checkOutput("add_max", {16'd0, result}, 32'h01FE);
    applyStimulus(OP_SUB, 8'd3, 8'd4, latency, busy_first);
    checkOutput("sub_result", {16'd0, result}, 32'hFFFF);
    applyStimulus(OP_MULT, 8'd255, 8'd255, latency, busy_first);
    checkOutput("mult_result", {16'd0, result}, 32'hFE01);

    // Division, including divide-by-zero.
    applyStimulus(OP_DIV, 8'd100, 8'd7, latency, busy_first);
    checkOutput("div_lat", latency, 32'd9);
    checkOutput("div_busy", {31'd0, busy_first}, 32'd1);
    checkOutput("div_result", {16'd0, result}, 32'd14);
    checkOutput("div_rem", {24'd0, remainder}, 32'd2);
    applyStimulus(OP_DIV, 8'd5, 8'd0, latency, busy_first);
    checkOutput("div0_lat", latency, 32'd1);
    checkOutput("div0_err", {31'd0, err}, 32'd1);
    checkOutput("div0_result", {16'd0, result}, 32'hFFFF);
    checkOutput("div0_rem", {24'd0, remainder}, 32'd5);

    // GCD, including zero operands.
    applyStimulus(OP_GCD, 8'd48, 8'd18, latency, busy_first);
    checkOutput("gcd_48_18", {16'd0, result}, 32'd6);
    checkOutput("gcd_err", {31'd0, err}, 32'd0);
    applyStimulus(OP_GCD, 8'd0, 8'd9, latency, busy_first);
    checkOutput("gcd_0_9", {16'd0, result}, 32'd9);
    applyStimulus(OP_GCD, 8'd9, 8'd0, latency, busy_first);
    checkOutput("gcd_9_0", {16'd0, result}, 32'd9);
    applyStimulus(OP_GCD, 8'd0, 8'd0, latency, busy_first);
    checkOutput("gcd_0_0", {16'd0, result}, 32'd0);

    // An add strobe while gcd is running must be dropped, not queued.
    @(negedge clk);
    {add, sub, mult, div, gcd, isprime, sqrt} = OP_GCD;
    num1 = 8'd48;
    num2 = 8'd18;
    @(negedge clk);
    done_count = done ? 1 : 0;
    {add, sub, mult, div, gcd, isprime, sqrt} = OP_ADD;
    num1 = 8'd1;
    num2 = 8'd1;
    @(negedge clk);
    {add, sub, mult, div, gcd, isprime, sqrt} = 7'b0;
    if (done) done_count++;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) done_count++;
    end
    checkOutput("ignore_done_count", done_count, 32'd1);
    checkOutput("ignore_result", {16'd0, result}, 32'd6);

    // Primality.
    applyStimulus(OP_PRIME, 8'd97, 8'd0, latency, busy_first);
    checkOutput("prime97_flag", {31'd0, prime}, 32'd1);
    checkOutput("prime97_result", {16'd0, result}, 32'd97);
    applyStimulus(OP_PRIME, 8'd91, 8'd0, latency, busy_first);
    checkOutput("prime91_flag", {31'd0, prime}, 32'd0);
    checkOutput("prime91_result", {16'd0, result}, 32'd7);
    applyStimulus(OP_PRIME, 8'd1, 8'd0, latency, busy_first);
    checkOutput("prime1_lat", latency, 32'd1);
    checkOutput("prime1_flag", {31'd0, prime}, 32'd0);
    checkOutput("prime1_result", {16'd0, result}, 32'd0);
    applyStimulus(OP_PRIME, 8'd2, 8'd0, latency, busy_first);
    checkOutput("prime2_flag", {31'd0, prime}, 32'd1);
    checkOutput("prime2_result", {16'd0, result}, 32'd2);
    applyStimulus(OP_PRIME, 8'd4, 8'd0, latency, busy_first);
    checkOutput("prime4_flag", {31'd0, prime}, 32'd0);
    checkOutput("prime4_result", {16'd0, result}, 32'd2);

    // Square root.
    applyStimulus(OP_SQRT, 8'd200, 8'd0, latency, busy_first);
    checkOutput("sqrt200_lat", latency, 32'd5);
    checkOutput("sqrt200_result", {16'd0, result}, 32'd14);
    checkOutput("sqrt200_rem", {24'd0, remainder}, 32'd4);
    applyStimulus(OP_SQRT, 8'd255, 8'd0, latency, busy_first);
    checkOutput("sqrt255_result", {16'd0, result}, 32'd15);
    checkOutput("sqrt255_rem", {24'd0, remainder}, 32'd30);

    // Two strobes at once is an error.
    applyStimulus(OP_ADD | OP_SUB, 8'd7, 8'd3, latency, busy_first);
    checkOutput("multi_lat", latency, 32'd1);
    checkOutput("multi_err", {31'd0, err}, 32'd1);
    checkOutput("multi_result", {16'd0, result}, 32'd0);

    // Load a nonzero result, then abort a division with reset.
    applyStimulus(OP_SQRT, 8'd200, 8'd0, latency, busy_first);
    @(negedge clk);
    {add, sub, mult, div, gcd, isprime, sqrt} = OP_DIV;
    num1 = 8'd100;
    num2 = 8'd7;
    @(negedge clk);
    {add, sub, mult, div, gcd, isprime, sqrt} = 7'b0;
    checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_result", {16'd0, result}, 32'd0);
    checkOutput("abort_rem", {24'd0, remainder}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    done_count = done ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_count++;
    end
    checkOutput("abort_no_done", done_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  // Global guard so the run always ends even if a wait is somehow missed.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
